ram_rd_streamer: RTL and testbench
==================================

# ram_rd_streamer

Read-side initiator for the team's dual-port register RAM (registered read, one-cycle read latency). It accepts a burst command (base address and word count) and issues one RAM read per cycle on the RAM's read port. Returned words go into a two-entry output buffer and leave on a valid/ready stream, so downstream backpressure never loses data. It sits between a RAM instance and any consumer stage that wants streamed words instead of raw addresses.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width; matches the RAM's SRAM_ADDR_WIDTH
- DATA_WIDTH, 64, RAM word width; matches the RAM's SRAM_WIDTH
- LEN_WIDTH, ADDR_WIDTH+1, burst length width; allows lengths 0..2^ADDR_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_vld  in  1  burst command valid
- cmd_rdy  out  1  command accepted when cmd_vld && cmd_rdy
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  number of words
- ram_read_en  out  1  to the RAM read_en
- ram_addr_r  out  ADDR_WIDTH  to the RAM addr_r
- ram_data_out  in  DATA_WIDTH  from the RAM data_out; valid the cycle after ram_read_en
- out_vld  out  1  output word valid
- out_rdy  in  1  consumer ready
- out_data  out  DATA_WIDTH  output word
- out_last  out  1  marks the final word of a burst; qualified by out_vld
- busy  out  1  high whenever state is not IDLE

## Operation
- The FSM has three states: IDLE, READ and DRAIN.
- **IDLE**
  - cmd_rdy=1.
  - On a handshake with cmd_len>0: latch addr=cmd_addr, set remaining=cmd_len, go to READ.
  - On a handshake with cmd_len=0: the command is consumed, state stays IDLE, and no output is produced.
- **READ**
  - cmd_rdy=0.
  - Issue condition: issue = (remaining>0) && (fifo_cnt + inflight − pop < 2).
    - inflight = 1 if ram_read_en was high last cycle.
    - pop = out_vld && out_rdy.
  - ram_read_en = issue. This term is combinational from registered state, fifo_cnt, inflight and out_rdy.
  - ram_addr_r = addr.
  - On issue: addr increments modulo 2^ADDR_WIDTH (wraps from max to 0), and remaining decrements.
  - When the issue that takes remaining to 0 occurs, go to DRAIN.
- **DRAIN**
  - No reads are issued.
  - Go to IDLE once inflight=0 and fifo_cnt=0, or once the final pop happens with nothing in flight.
  - The next command can therefore be accepted the cycle after the last word is popped.
- **Capture:** when inflight=1, ram_data_out is written into the 2-entry FIFO. The tag last = (this word is the final word of the burst) is stored alongside the data.
- **Output:**
  - out_vld = (fifo_cnt>0).
  - out_data and out_last come from the FIFO head.
  - The head stays stable while out_vld && !out_rdy.
- Push and pop can occur in the same cycle. fifo_cnt is unchanged in that case. Overflow is impossible by the issue rule.
- The block never drives the RAM write port.

## Timing
- Reset values:
  - state=IDLE, cmd_rdy=1, busy=0.
  - ram_read_en=0, ram_addr_r=0.
  - out_vld=0, out_data=0, out_last=0.
  - fifo_cnt=0, inflight=0, remaining=0.
- **Latency:**
  - Handshake in cycle C0.
  - First ram_read_en in C1.
  - RAM data is valid in C2 and captured at the end of C2.
  - out_vld=1 from C3.
- **Throughput:** with out_rdy held at 1, one read is issued per cycle and one word is output per cycle. An N-word burst outputs its words in C3..C(N+2), with out_last in C(N+2).
- **Backpressure:** if out_rdy stays 0, issue continues until fifo_cnt + inflight = 2, then ram_read_en=0. Issue resumes in the same cycle that a pop is seen.
- **busy:** rises the cycle after accepting a burst with len>0. It falls in the cycle after DRAIN exits.
- **Reset mid-burst:**
  - All state clears immediately (asynchronous).
  - Buffered words are discarded.
  - ram_read_en drops at once.
  - The first cmd_rdy=1 appears while rst_n is low.

## Test plan
- **4-word burst:** RAM preloaded with mem[i]=0x100+i; cmd addr=8, len=4, out_rdy=1. Required: ram_addr_r = 8,9,10,11 in C1..C4; out_data = 0x108..0x10B in C3..C6; out_last only with 0x10B; busy falls after C6.
- **Zero length:** cmd len=0. Required: handshake completes, busy stays 0, no ram_read_en, no out_vld, cmd_rdy remains 1.
- **Backpressure:** len=6 with out_rdy=0 for 10 cycles, then 1. Required: exactly 2 reads before the stall; out_data holds 0x100 stable during the stall; after release, all 6 words come out in order with no duplicate or lost word.
- **Wrap-around:** ADDR_WIDTH=10, addr=1022, len=4. Required: ram_addr_r = 1022, 1023, 0, 1, and data arrives in that order.
- **Back-to-back commands:** cmd_vld held high with two commands queued. Required: cmd_rdy=0 during the first burst; the second burst is accepted only after the first out_last pops; both bursts' data are correct.
- **Reset mid-burst:** assert rst_n=0 at C4 of a len=8 burst. Required: out_vld, ram_read_en and busy go to 0 immediately; after release, a fresh len=2 burst returns correct data with out_last on word 2.

Source files
------------

// File: rtl/ram_rd_streamer_if.sv
`default_nettype none
// ============================================================================
//  ram_rd_streamer_if
//  Command, RAM read-port and output-stream signals of the RAM read streamer.
//  Revision: 1.0
// ============================================================================
interface ram_rd_streamer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  ram_read_en;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  out_vld;
  logic                  out_rdy;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    input  cmd_vld, cmd_addr, cmd_len, ram_data_out, out_rdy,
    output cmd_rdy, ram_read_en, ram_addr_r, out_vld, out_data, out_last, busy
  );

  modport slave (
    output cmd_vld, cmd_addr, cmd_len, ram_data_out, out_rdy,
    input  cmd_rdy, ram_read_en, ram_addr_r, out_vld, out_data, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_rd_streamer.sv
`default_nettype none
// ============================================================================
//  ram_rd_streamer
//  Turns a (base address, length) burst command into one RAM read per cycle
//  and streams the returned words out through a two-entry buffer.
//  Revision: 1.0
// ============================================================================
module ram_rd_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ram_rd_streamer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic [1:0]            fifo_last_q, fifo_last_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic                  cmd_rdy_q, cmd_rdy_d;
  logic                  busy_q, busy_d;

  logic                  cmd_hs;
  logic                  out_vld;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;

  assign cmd_hs    = bus.cmd_vld && cmd_rdy_q;
  assign out_vld   = (fifo_cnt_q != 2'd0);
  assign pop       = out_vld && bus.out_rdy;
  assign push      = inflight_q;
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};

  // A pop this cycle frees a slot, so a read may be issued into it right away.
  assign issue = (state_q == ST_READ) && (remaining_q != '0) &&
                 (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = issue;
    inflight_last_d = issue && (remaining_q == LEN_WIDTH'(1));
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fifo_cnt_d      = fifo_cnt_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = bus.ram_data_out;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (issue) begin
      addr_d      = addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - LEN_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Zero-length commands are consumed without leaving IDLE.
        if (cmd_hs && (bus.cmd_len != '0)) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (issue && (remaining_q == LEN_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_cnt_d == 2'd0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_rdy_d = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= 2'b00;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
      cmd_rdy_q       <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
      cmd_rdy_q       <= cmd_rdy_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.busy        = busy_q;
  assign bus.ram_read_en = issue;
  assign bus.ram_addr_r  = addr_q;
  assign bus.out_vld     = out_vld;
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_last    = fifo_last_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_ram_rd_streamer
//  Directed bench with a RAM model and a queue-based output scoreboard.
//  Revision: 1.0
// ============================================================================
module tb_ram_rd_streamer;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 11;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   rd_count = 0;

  word_t         exp_q[$];
  logic [AW-1:0] addr_exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_rd_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM: data valid the cycle after read_en
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 64'h100 + 64'(i);
  always @(posedge clk) if (bus.ram_read_en) bus.ram_data_out <= mem[bus.ram_addr_r];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: read addresses and popped words against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_read_en) begin
        rd_count++;
        if (addr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: actual addr=%0d required no read (cycle %0d)",
                   bus.ram_addr_r, cyc);
        end else begin
          check_val("read_addr", 64'(bus.ram_addr_r), 64'(addr_exp_q.pop_front()));
        end
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: actual data=%0h required no output (cycle %0d)",
                   bus.out_data, cyc);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check_val("out_data", bus.out_data, w.data);
          check_bit("out_last", bus.out_last, w.last);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] n, input bit keep,
                      output int c0);
    for (int i = 0; i < int'(n); i++) begin
      logic [AW-1:0] wa;
      word_t         w;
      wa     = a + AW'(i);
      w.data = 64'h100 + 64'(wa);
      w.last = (i == int'(n) - 1);
      addr_exp_q.push_back(wa);
      exp_q.push_back(w);
    end
    bus.cmd_addr = a;
    bus.cmd_len  = n;
    bus.cmd_vld  = 1'b1;
    c0 = -1;
    for (int k = 0; k < 200 && c0 < 0; k++) begin
      @(negedge clk);
      if (bus.cmd_rdy) c0 = cyc;
    end
    if (c0 < 0) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: actual cmd_rdy=0 for 200 cycles required accept");
    end
    @(posedge clk); #1;
    if (!keep) bus.cmd_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy !== 1'b0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_int("drain_words_left", exp_q.size(), 0);
    check_bit("drain_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int c0, c0b, rd_base;
    bus.cmd_vld  = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len  = '0;
    bus.out_rdy  = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check_bit("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_read_en", bus.ram_read_en, 1'b0);
    check_val("rst_addr_r", 64'(bus.ram_addr_r), 64'h0);
    check_bit("rst_out_vld", bus.out_vld, 1'b0);
    check_val("rst_out_data", bus.out_data, 64'h0);
    check_bit("rst_out_last", bus.out_last, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();

    // 4-word burst: reads C1..C4, outputs C3..C6, busy falls at C7
    send(10'd8, 11'd4, 1'b0, c0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_bit("t1_read_en", bus.ram_read_en, (k <= 4));
      check_bit("t1_out_vld", bus.out_vld, (k >= 3 && k <= 6));
      check_bit("t1_busy", bus.busy, (k <= 6));
      if (k >= 3 && k <= 6) check_bit("t1_out_last", bus.out_last, (k == 6));
    end
    wait_drain();

    // Zero length
    sync();
    rd_base = rd_count;
    send(10'd5, 11'd0, 1'b0, c0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_bit("t2_busy", bus.busy, 1'b0);
      check_bit("t2_cmd_rdy", bus.cmd_rdy, 1'b1);
      check_bit("t2_out_vld", bus.out_vld, 1'b0);
      check_bit("t2_read_en", bus.ram_read_en, 1'b0);
    end
    check_int("t2_reads", rd_count - rd_base, 0);

    // Backpressure: 10 stalled cycles
    sync();
    bus.out_rdy = 1'b0;
    rd_base = rd_count;
    send(10'd0, 11'd6, 1'b0, c0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check_bit("t3_hold_vld", bus.out_vld, 1'b1);
        check_val("t3_hold_data", bus.out_data, 64'h100);
      end
    end
    check_int("t3_reads_in_stall", rd_count - rd_base, 2);
    sync();
    bus.out_rdy = 1'b1;
    wait_drain();

    // Wrap-around at the top of the address space
    sync();
    send(10'd1022, 11'd4, 1'b0, c0);
    wait_drain();

    // Back-to-back: second command accepted the cycle after the first last pop
    sync();
    send(10'd20, 11'd3, 1'b1, c0);
    send(10'd40, 11'd2, 1'b0, c0b);
    check_int("t5_second_accept_cycle", c0b - c0, 6);
    wait_drain();

    // Reset in C4 of a len=8 burst
    sync();
    send(10'd100, 11'd8, 1'b0, c0);
    repeat (3) @(posedge clk);
    #1;
    check_bit("t6_pre_out_vld", bus.out_vld, 1'b1);
    check_bit("t6_pre_read_en", bus.ram_read_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("t6_rst_out_vld", bus.out_vld, 1'b0);
    check_bit("t6_rst_read_en", bus.ram_read_en, 1'b0);
    check_bit("t6_rst_busy", bus.busy, 1'b0);
    check_bit("t6_rst_cmd_rdy", bus.cmd_rdy, 1'b1);
    exp_q.delete();
    addr_exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();
    send(10'd200, 11'd2, 1'b0, c0);
    wait_drain();

    repeat (3) sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
